minhash_ctrl: RTL and testbench
===============================

MINHASH_CTRL -- requirements
Module: minhash_ctrl

Interface
REQ-001 The block SHALL have parameter KMER_LEN, default 4: bases per k-mer; legal range 1..FRAG_BASES.
REQ-002 The block SHALL have parameter FRAG_BASES, default 8: bases per fragment.
REQ-003 The block SHALL have parameter NUM_HASH, default 2: hash seeds per k-mer, all sharing one hash unit.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream base available.
REQ-007 The block SHALL have port out_wait, output, 1 bit: stall upstream; a base is accepted iff in_valid && !out_wait.
REQ-008 The block SHALL have port shift_en, output, 1 bit: shift the accepted base into the datapath k-mer register this cycle.
REQ-009 The block SHALL have port hash_req, output, 1 bit: request to the shared hash unit.
REQ-010 The block SHALL have port hash_ready, input, 1 bit: hash unit accepts hash_req this cycle.
REQ-011 The block SHALL have port hash_sel, output, $clog2(NUM_HASH) bits (min 1): seed index for the current request.
REQ-012 The block SHALL have port kmer_idx, output, $clog2(FRAG_BASES) bits (min 1): index of the k-mer being hashed.
REQ-013 The block SHALL have port min_clr, output, 1 bit: clear datapath min registers.
REQ-014 The block SHALL have port frag_done, output, 1 bit: one-cycle pulse; datapath signature is complete.

Function
REQ-015 The block SHALL implement FSM states FILL, HASH, NEXT and DONE.
REQ-016 FILL SHALL drive out_wait=0 and shift_en=in_valid; each accepted base SHALL increment base_cnt; on the KMER_LEN-th accepted base the FSM SHALL go to HASH with seed_cnt=0 and kmer_idx=0.
REQ-017 HASH SHALL drive out_wait=1, shift_en=0, hash_req=1 and hash_sel=seed_cnt; on hash_ready, seed_cnt SHALL increment.
REQ-018 On the hash_ready handshake with seed_cnt==NUM_HASH-1, seed_cnt SHALL clear and the FSM SHALL go to DONE if base_cnt==FRAG_BASES, else to NEXT.
REQ-019 While hash_ready=0, hash_req, hash_sel and kmer_idx SHALL hold stable indefinitely, and no base SHALL be accepted.
REQ-020 NEXT SHALL drive out_wait=0; an accepted base SHALL assert shift_en, increment base_cnt and kmer_idx, and move the FSM to HASH.
REQ-021 DONE SHALL last exactly one cycle, asserting frag_done=1 and min_clr=1 with out_wait=1; it SHALL clear base_cnt, kmer_idx and seed_cnt and then go to FILL.
REQ-022 Each fragment SHALL issue exactly (FRAG_BASES-KMER_LEN+1)*NUM_HASH hash handshakes.
REQ-023 in_valid seen in HASH or DONE SHALL be ignored, and the base SHALL NOT count as accepted.
REQ-024 When KMER_LEN==FRAG_BASES, the FSM SHALL go FILL -> HASH -> DONE with no NEXT visit.
REQ-025 In all states other than HASH, hash_req SHALL be 0.
REQ-026 All counters SHALL be sized to hold their maximum value without wrap.

Reset
REQ-027 While rst_n=0 at a clock edge, the block SHALL set FSM=FILL and clear all counters to 0; hash_req=0, shift_en=0, frag_done=0, min_clr=0 and out_wait=1 SHALL be forced while rst_n=0.
REQ-028 Reset in any state, including mid-HASH, SHALL abandon the fragment without a frag_done pulse; the first cycle after reset deasserts SHALL be FILL with out_wait=0.

Structure
REQ-029 KMER_LEN, FRAG_BASES, NUM_HASH defaults and the FSM state enum type SHALL live in proj_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; it SHALL contain only control logic and SHALL NOT carry any base data.

Verification
REQ-031 Bench scenario, defaults, in_valid=1, hash_ready=1 -> 4 shift_en cycles; then 5 k-mers with hash_sel 0,1 each and kmer_idx 0..4; 4 NEXT shifts; frag_done 19 cycles after reset release; 10 handshakes total.
REQ-032 Bench scenario, hash_ready=0 for 5 cycles in the first HASH -> hash_req=1, hash_sel=0, kmer_idx=0 and out_wait=1 held all 5 cycles; shift_en=0; frag_done delayed by 5 cycles.
REQ-033 Bench scenario, in_valid toggling 1,0,1,0 in FILL -> only cycles with in_valid=1 shift; HASH entered after the 4th accepted base.
REQ-034 Bench scenario, rst_n=0 for one cycle during kmer_idx=2 HASH -> no frag_done; after release FILL with counters 0; the next fragment completes normally.
REQ-035 Bench scenario, two back-to-back fragments -> exactly two frag_done pulses, each coincident with min_clr; shift_en resumes the cycle after each DONE.
REQ-036 Bench scenario, KMER_LEN=8, FRAG_BASES=8, NUM_HASH=2 -> 8 shifts, 2 handshakes, then frag_done; NEXT is never visited.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared definitions for the minhash control block.
//   - Default k-mer length, fragment length and number of hash seeds.
//   - FSM state type used by minhash_ctrl.
//   - clog2_min1(): port-width helper that never returns 0.
package proj_pkg;

   localparam int unsigned KMER_LEN_DEF   = 4;
   localparam int unsigned FRAG_BASES_DEF = 8;
   localparam int unsigned NUM_HASH_DEF   = 2;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_HASH = 2'd1,
      ST_NEXT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Bit width needed to index v items, at least one bit.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/minhash_ctrl.sv
// Control FSM for a MinHash signature engine. It sequences bases into the
// datapath k-mer register, issues one request per (k-mer, seed) pair to a
// shared hash unit, and flags fragment completion. No base data passes here.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   in_valid    in   upstream base available
//   out_wait    out  stall upstream; a base is accepted iff in_valid && !out_wait
//   shift_en    out  shift the accepted base into the k-mer register
//   hash_req    out  request to the shared hash unit
//   hash_ready  in   hash unit takes hash_req this cycle
//   hash_sel    out  seed index of the current request
//   kmer_idx    out  index of the k-mer being hashed
//   min_clr     out  clear datapath min registers
//   frag_done   out  one-cycle pulse, signature complete
module minhash_ctrl
   import proj_pkg::*;
#(
   parameter int unsigned KMER_LEN   = KMER_LEN_DEF,
   parameter int unsigned FRAG_BASES = FRAG_BASES_DEF,
   parameter int unsigned NUM_HASH   = NUM_HASH_DEF
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  out_wait,
   output logic                                  shift_en,
   output logic                                  hash_req,
   input  logic                                  hash_ready,
   output logic [clog2_min1(NUM_HASH)-1:0]       hash_sel,
   output logic [clog2_min1(FRAG_BASES)-1:0]     kmer_idx,
   output logic                                  min_clr,
   output logic                                  frag_done
);

   localparam int unsigned SEL_W = clog2_min1(NUM_HASH);
   localparam int unsigned IDX_W = clog2_min1(FRAG_BASES);
   // base_cnt must reach FRAG_BASES itself, hence the +1.
   localparam int unsigned CNT_W = $clog2(FRAG_BASES + 1);

   localparam logic [CNT_W-1:0] LAST_FILL = CNT_W'(KMER_LEN - 1);
   localparam logic [CNT_W-1:0] FRAG_END  = CNT_W'(FRAG_BASES);
   localparam logic [SEL_W-1:0] LAST_SEED = SEL_W'(NUM_HASH - 1);

   state_e             r_state,    w_state_d;
   logic [CNT_W-1:0]   r_base_cnt, w_base_cnt_d;
   logic [SEL_W-1:0]   r_seed_cnt, w_seed_cnt_d;
   logic [IDX_W-1:0]   r_kmer_idx, w_kmer_idx_d;

   logic               w_open;
   logic               w_accept;

   // Only FILL and NEXT take bases; HASH and DONE stall upstream.
   assign w_open   = (r_state == ST_FILL) || (r_state == ST_NEXT);
   assign w_accept = rst_n && in_valid && w_open;

   always_comb begin
      w_state_d    = r_state;
      w_base_cnt_d = r_base_cnt;
      w_seed_cnt_d = r_seed_cnt;
      w_kmer_idx_d = r_kmer_idx;
      unique case (r_state)
         ST_FILL: begin
            if (w_accept) begin
               w_base_cnt_d = r_base_cnt + 1'b1;
               if (r_base_cnt == LAST_FILL) begin
                  w_state_d    = ST_HASH;
                  w_seed_cnt_d = '0;
                  w_kmer_idx_d = '0;
               end
            end
         end
         ST_HASH: begin
            if (hash_ready) begin
               if (r_seed_cnt == LAST_SEED) begin
                  w_seed_cnt_d = '0;
                  w_state_d    = (r_base_cnt == FRAG_END) ? ST_DONE : ST_NEXT;
               end else begin
                  w_seed_cnt_d = r_seed_cnt + 1'b1;
               end
            end
         end
         ST_NEXT: begin
            if (w_accept) begin
               w_base_cnt_d = r_base_cnt + 1'b1;
               w_kmer_idx_d = r_kmer_idx + 1'b1;
               w_state_d    = ST_HASH;
            end
         end
         ST_DONE: begin
            w_base_cnt_d = '0;
            w_seed_cnt_d = '0;
            w_kmer_idx_d = '0;
            w_state_d    = ST_FILL;
         end
         default: begin
            w_state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_FILL;
         r_base_cnt <= '0;
         r_seed_cnt <= '0;
         r_kmer_idx <= '0;
      end else begin
         r_state    <= w_state_d;
         r_base_cnt <= w_base_cnt_d;
         r_seed_cnt <= w_seed_cnt_d;
         r_kmer_idx <= w_kmer_idx_d;
      end
   end

   // Strobes are gated with rst_n so they are quiet during the reset cycle
   // itself, not only after the registers have been cleared.
   assign out_wait  = !rst_n || !w_open;
   assign shift_en  = w_accept;
   assign hash_req  = rst_n && (r_state == ST_HASH);
   assign frag_done = rst_n && (r_state == ST_DONE);
   assign min_clr   = rst_n && (r_state == ST_DONE);
   assign hash_sel  = r_seed_cnt;
   assign kmer_idx  = r_kmer_idx;

endmodule

// File: tb/tb_minhash_ctrl.sv
// Bench for minhash_ctrl. The reference model expands each fragment into a
// schedule of steps (accept base / hash seed s of k-mer k / done) and checks
// the DUT cycle by cycle against the head of that schedule.
module tb_minhash_ctrl;

   localparam int KAcc  = 0;
   localparam int KHash = 1;
   localparam int KDone = 2;

   typedef struct {
      int kind;
      int seed;
      int kidx;
   } step_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic hash_ready = 1'b0;

   logic       a_wait, a_shift, a_req, a_sel, a_clr, a_done;
   logic [2:0] a_kidx;
   logic       b_wait, b_shift, b_req, b_sel, b_clr, b_done;
   logic [2:0] b_kidx;

   logic       sel_b = 1'b0;
   logic       o_wait, o_shift, o_req, o_sel, o_clr, o_done;
   logic [2:0] o_kidx;

   always #5 clk = ~clk;

   minhash_ctrl u_dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .out_wait   (a_wait),
      .shift_en   (a_shift),
      .hash_req   (a_req),
      .hash_ready (hash_ready),
      .hash_sel   (a_sel),
      .kmer_idx   (a_kidx),
      .min_clr    (a_clr),
      .frag_done  (a_done)
   );

   minhash_ctrl #(
      .KMER_LEN   (8),
      .FRAG_BASES (8),
      .NUM_HASH   (2)
   ) u_dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .out_wait   (b_wait),
      .shift_en   (b_shift),
      .hash_req   (b_req),
      .hash_ready (hash_ready),
      .hash_sel   (b_sel),
      .kmer_idx   (b_kidx),
      .min_clr    (b_clr),
      .frag_done  (b_done)
   );

   assign o_wait  = sel_b ? b_wait  : a_wait;
   assign o_shift = sel_b ? b_shift : a_shift;
   assign o_req   = sel_b ? b_req   : a_req;
   assign o_sel   = sel_b ? b_sel   : a_sel;
   assign o_clr   = sel_b ? b_clr   : a_clr;
   assign o_done  = sel_b ? b_done  : a_done;
   assign o_kidx  = sel_b ? b_kidx  : a_kidx;

   int n_tests = 0;
   int n_fail  = 0;

   // Model parameters of the DUT currently under check.
   int pk = 4;
   int pf = 8;
   int ph = 2;

   step_t q[$];
   int cyc, n_shift, n_hs, hs_frag, n_frag, last_done_cyc, first_req_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
      end
   endtask

   // One fragment: KMER_LEN bases, then each k-mer hashed with every seed,
   // one more base between consecutive k-mers, then a single done cycle.
   task automatic refill();
      for (int b = 0; b < pk; b++) q.push_back('{KAcc, 0, 0});
      for (int k = 0; k <= pf - pk; k++) begin
         for (int s = 0; s < ph; s++) q.push_back('{KHash, s, k});
         if (k < pf - pk) q.push_back('{KAcc, 0, 0});
      end
      q.push_back('{KDone, 0, 0});
   endtask

   task automatic step(input logic v, input logic r, input logic rn);
      step_t h;
      in_valid   = v;
      hash_ready = r;
      rst_n      = rn;
      @(negedge clk);
      if (!rn) begin
         chk("rst_out_wait", o_wait, 1);
         chk("rst_shift_en", o_shift, 0);
         chk("rst_hash_req", o_req, 0);
         chk("rst_frag_done", o_done, 0);
         chk("rst_min_clr", o_clr, 0);
      end else begin
         cyc++;
         if (q.size() == 0) refill();
         h = q[0];
         chk("out_wait", o_wait, (h.kind != KAcc));
         chk("shift_en", o_shift, (h.kind == KAcc) && v);
         chk("hash_req", o_req, (h.kind == KHash));
         chk("frag_done", o_done, (h.kind == KDone));
         chk("min_clr", o_clr, (h.kind == KDone));
         if (h.kind == KHash) begin
            chk("hash_sel", o_sel, h.seed);
            chk("kmer_idx", o_kidx, h.kidx);
         end
         if (cyc == 1) begin
            chk("post_rst_kmer_idx", o_kidx, 0);
            chk("post_rst_hash_sel", o_sel, 0);
         end
         if (o_shift === 1'b1) n_shift++;
         if (o_req === 1'b1 && first_req_cyc == 0) first_req_cyc = cyc;
         if (o_req === 1'b1 && r) begin
            n_hs++;
            hs_frag++;
         end
         if (o_done === 1'b1) begin
            n_frag++;
            last_done_cyc = cyc;
            chk("hs_per_frag", hs_frag, (pf - pk + 1) * ph);
            hs_frag = 0;
         end
      end
      @(posedge clk);
      if (!rn) begin
         q.delete();
         cyc = 0; n_shift = 0; n_hs = 0; hs_frag = 0;
         n_frag = 0; last_done_cyc = 0; first_req_cyc = 0;
      end else if (q.size() > 0) begin
         case (q[0].kind)
            KAcc:    if (v) void'(q.pop_front());
            KHash:   if (r) void'(q.pop_front());
            default: void'(q.pop_front());
         endcase
      end
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Basic fragment, upstream and hash unit always ready.
      step(1, 1, 0);
      step(1, 1, 0);
      for (int i = 0; i < 19; i++) step(1, 1, 1);
      chk("s1_done_cycle", last_done_cyc, 19);
      chk("s1_handshakes", n_hs, 10);
      chk("s1_shifts", n_shift, 8);
      chk("s1_frags", n_frag, 1);

      // Hash unit stalls for 5 cycles on the first request.
      step(1, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 1);
      for (int i = 0; i < 40 && n_frag == 0; i++) step(1, 1, 1);
      chk("s2_done_cycle", last_done_cyc, 24);
      chk("s2_handshakes", n_hs, 10);

      // Toggling in_valid during FILL.
      step(1, 1, 0);
      for (int i = 0; i < 7; i++) step(((i % 2) == 0), 1, 1);
      for (int i = 0; i < 40 && n_frag == 0; i++) step(1, 1, 1);
      chk("s3_first_req", first_req_cyc, 8);
      chk("s3_done_cycle", last_done_cyc, 22);

      // Reset while hashing k-mer 2, then a clean fragment.
      step(1, 1, 0);
      for (int i = 0; i < 40 && !(q.size() > 0 && q[0].kind == KHash && q[0].kidx == 2); i++)
         step(1, 1, 1);
      chk("s4_at_kidx2", o_kidx, 2);
      chk("s4_hash_req", o_req, 1);
      chk("s4_no_frag", n_frag, 0);
      step(1, 1, 0);
      for (int i = 0; i < 19; i++) step(1, 1, 1);
      chk("s4_done_cycle", last_done_cyc, 19);
      chk("s4_frags", n_frag, 1);

      // Two back-to-back fragments.
      step(1, 1, 0);
      for (int i = 0; i < 38; i++) step(1, 1, 1);
      chk("s5_frags", n_frag, 2);
      chk("s5_last_done", last_done_cyc, 38);
      chk("s5_handshakes", n_hs, 20);

      // Random traffic with occasional resets.
      step(1, 1, 0);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(49) != 0));

      // KMER_LEN == FRAG_BASES: no NEXT phase.
      sel_b = 1'b1;
      pk = 8; pf = 8; ph = 2;
      step(1, 1, 0);
      for (int i = 0; i < 100 && n_frag == 0; i++) step($urandom_range(1), $urandom_range(1), 1);
      chk("b_frags", n_frag, 1);
      chk("b_shifts", n_shift, 8);
      chk("b_handshakes", n_hs, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
